uart_reg_rx: RTL

Parametrised serial register-write receiver, successor to the single-channel two-byte UART decoder. Recovers 8N1 frames from an asynchronous `rx` line with a programmable clocks-per-bit divider, pairs a low byte (msb=0) with a high byte (msb=1) into an address/data write, and queues decoded writes in a small FIFO with a valid/ready handshake. It sits between the chip's serial input pin and the register file, and adds framing, pairing and overflow error reporting.

---
 rtl/uart_reg_rx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_reg_rx.sv
// Serial register-write receiver: 8N1 frame recovery, low/high byte pairing and a show-ahead write FIFO.
// Define UART_PARITY_EN to receive 8E1 frames with an even parity check.
module uart_reg_rx #(
  parameter int CLK_DIV = 5,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err,
  output logic              pair_err,
  output logic              overflow
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] CNT_HALF = CW'((CLK_DIV - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  logic              rx_meta_r, rxs_r, rxs_d_r;
  logic              fall_s;
  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shreg_r;
  logic [6:0]        hold_r;
  logic              hold_valid_r;
  logic              push_pend_r;
  logic [ADDR_W-1:0] push_addr_r;
  logic [7:0]        push_data_r;
  logic              frame_err_r, pair_err_r;
  logic              stop_bad_s;
`ifdef UART_PARITY_EN
  logic              par_bad_r;
`endif

  logic [ADDR_W+7:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r, wr_ptr_n_s, rd_ptr_n_s;
  logic              full_s, empty_n_s, push_s, pop_s;
  logic [ADDR_W+7:0] head_n_s;
  logic              wr_valid_r, overflow_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
      rxs_d_r   <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rxs_r     <= rx_meta_r;
      rxs_d_r   <= rxs_r;
    end
  end

  // Edge detect and stop-bit verdict (parity failure counts as a bad stop).
  always_comb begin
    fall_s = rxs_d_r & ~rxs_r;
`ifdef UART_PARITY_EN
    stop_bad_s = ~rxs_r | par_bad_r;
`else
    stop_bad_s = ~rxs_r;
`endif
  end

  // Receive FSM with byte pairing; pairing decision is made on the stop sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= CNT_ZERO;
      bit_idx_r    <= 3'd0;
      shreg_r      <= 8'd0;
      hold_r       <= 7'd0;
      hold_valid_r <= 1'b0;
      push_pend_r  <= 1'b0;
      push_addr_r  <= {ADDR_W{1'b0}};
      push_data_r  <= 8'd0;
      frame_err_r  <= 1'b0;
      pair_err_r   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_r    <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      pair_err_r  <= 1'b0;
      push_pend_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (fall_s) begin
            state_r <= S_START;
            cnt_r   <= CNT_ZERO;
          end
        end
        S_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            state_r   <= rxs_r ? S_IDLE : S_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= CNT_ZERO;
            shreg_r   <= {rxs_r, shreg_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
              state_r <= S_PARITY;
`else
              state_r <= S_STOP;
`endif
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= CNT_ZERO;
            par_bad_r <= (rxs_r != even_parity(shreg_r));
            state_r   <= S_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= S_IDLE;
            if (stop_bad_s) begin
              frame_err_r  <= 1'b1;
              hold_valid_r <= 1'b0;
            end else if (!shreg_r[7]) begin
              hold_r       <= shreg_r[6:0];
              hold_valid_r <= 1'b1;
            end else if (hold_valid_r) begin
              push_pend_r  <= 1'b1;
              push_addr_r  <= shreg_r[ADDR_W:1];
              push_data_r  <= {shreg_r[0], hold_r};
              hold_valid_r <= 1'b0;
            end else begin
              pair_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // FIFO next-state: a push into a full FIFO only succeeds alongside a pop.
  always_comb begin
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s      = wr_valid_r & wr_ready;
    push_s     = push_pend_r & (~full_s | pop_s);
    wr_ptr_n_s = wr_ptr_r + {{(PW-1){1'b0}}, push_s};
    rd_ptr_n_s = rd_ptr_r + {{(PW-1){1'b0}}, pop_s};
    empty_n_s  = (rd_ptr_n_s == wr_ptr_n_s);
    if (rd_ptr_n_s == wr_ptr_r) begin
      head_n_s = {push_addr_r, push_data_r};
    end else begin
      head_n_s = mem_r[rd_ptr_n_s[AW-1:0]];
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {push_addr_r, push_data_r};
    end
  end

  // FIFO pointers and registered show-ahead head; head holds last value when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= 8'd0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_n_s;
      rd_ptr_r   <= rd_ptr_n_s;
      wr_valid_r <= ~empty_n_s;
      if (!empty_n_s) begin
        {wr_addr_r, wr_data_r} <= head_n_s;
      end
      if (push_pend_r && !push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign wr_valid  = wr_valid_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign frame_err = frame_err_r;
  assign pair_err  = pair_err_r;
  assign overflow  = overflow_r;

endmodule
